// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: scanout reads take the single RAM port first, then the
// clear-screen fill, then a small in-order FIFO of buffered pixel writes.
module fb_port_arbiter #(
   parameter int FB_DEPTH   = 19200,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              vgaclk,
   input  logic                              rst_n,
   input  logic                              scan_req,
   input  logic [ADDR_W-1:0]                 scan_addr,
   output logic [DATA_W-1:0]                 scan_data,
   output logic                              scan_valid,
   input  logic                              wr_valid,
   output logic                              wr_ready,
   input  logic [ADDR_W-1:0]                 wr_addr,
   input  logic [DATA_W-1:0]                 wr_data,
   output logic                              wr_err,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
   input  logic                              clr_start,
   input  logic [DATA_W-1:0]                 clr_color,
   output logic                              clr_busy,
   output logic                              clr_done,
   output logic                              mem_en,
   output logic                              mem_we,
   output logic [ADDR_W-1:0]                 mem_addr,
   output logic [DATA_W-1:0]                 mem_wdata,
   input  logic [DATA_W-1:0]                 mem_rdata
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state_reg;
   logic [ADDR_W-1:0]   clr_cnt_reg;
   logic [DATA_W-1:0]   clr_color_reg;
   logic                clr_done_reg;
   logic                scan_valid_reg;
   logic                wr_err_reg;
   logic [PTR_W-1:0]    wr_ptr_reg;
   logic [PTR_W-1:0]    rd_ptr_reg;
   logic [LVL_W-1:0]    level_reg;
   logic [ADDR_W-1:0]   fifo_addr_mem [FIFO_DEPTH];
   logic [DATA_W-1:0]   fifo_data_mem [FIFO_DEPTH];

   logic accept, in_range, push, pop, clr_step, clr_last;

   // Ready looks only at the registered level, so a full FIFO never falls through.
   assign wr_ready = (level_reg < LVL_W'(FIFO_DEPTH));
   assign accept   = wr_valid && wr_ready;
   assign in_range = (32'(wr_addr) < FB_DEPTH);
   assign push     = accept && in_range;
   assign pop      = rst_n && !scan_req && (state_reg == IDLE) && (level_reg != '0);
   assign clr_step = (state_reg == CLEAR) && !scan_req;
   assign clr_last = (clr_cnt_reg == ADDR_W'(FB_DEPTH - 1));

   assign scan_data  = mem_rdata;
   assign scan_valid = scan_valid_reg;
   assign wr_err     = wr_err_reg;
   assign fifo_level = level_reg;
   assign clr_busy   = (state_reg == CLEAR);
   assign clr_done   = clr_done_reg;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (rst_n) begin
         if (scan_req) begin
            mem_en   = 1'b1;
            mem_addr = scan_addr;
         end else if (state_reg == CLEAR) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_cnt_reg;
            mem_wdata = clr_color_reg;
         end else if (level_reg != '0) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = fifo_addr_mem[rd_ptr_reg];
            mem_wdata = fifo_data_mem[rd_ptr_reg];
         end
      end
   end

   always_ff @(posedge vgaclk) begin
      if (push) begin
         fifo_addr_mem[wr_ptr_reg] <= wr_addr;
         fifo_data_mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge vgaclk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         clr_cnt_reg    <= '0;
         clr_color_reg  <= '0;
         clr_done_reg   <= 1'b0;
         scan_valid_reg <= 1'b0;
         wr_err_reg     <= 1'b0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         level_reg      <= '0;
      end else begin
         scan_valid_reg <= scan_req;
         wr_err_reg     <= accept && !in_range;
         clr_done_reg   <= 1'b0;

         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase

         case (state_reg)
            IDLE: begin
               if (clr_start) begin
                  clr_color_reg <= clr_color;
                  clr_cnt_reg   <= '0;
                  state_reg     <= CLEAR;
               end
            end
            CLEAR: begin
               if (clr_step) begin
                  if (clr_last) begin
                     state_reg    <= IDLE;
                     clr_done_reg <= 1'b1;
                  end else begin
                     clr_cnt_reg <= clr_cnt_reg + 1'b1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
